demux1_2_ctrl1_buf: RTL and testbench

DEMUX1_2_CTRL1_BUF -- requirements
Module: demux1_2_ctrl1_buf

---
 rtl/demux1_2_ctrl1_buf.sv | 128 ++++++++++++
 tb/tb_demux1_2_ctrl1_buf.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/demux1_2_ctrl1_buf.sv
// demux1_2_ctrl1_buf -- 1-to-2 demultiplexer with a 2-entry FIFO on each output.
//   ctrl selects which queue takes input0 when in_valid && in_ready.
//   Each queue shows its head word on outputN with validN, and pops on validN && readyN.
//   Optional: define DEMUX_STATS_EN to add 8-bit wrapping pop counters stat0/stat1.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ctrl, input0        destination select, input word
//   in_valid, in_ready  input handshake (in_ready = selected queue not full)
//   output0/valid0/ready0, output1/valid1/ready1  per-queue output handshakes
//   stat0, stat1        (DEMUX_STATS_EN only) pop counts per queue

// One 2-deep FIFO lane. The head word is a registered entry, so there is no
// combinational path from wdata to rdata.
module demux1_2_queue #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            cnt;
  logic                  do_push, do_pop;

  assign valid   = (cnt != 2'd0);
  assign full    = (cnt == 2'd2);
  // Guard locally too, so a full queue can never be overwritten.
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  // Zero when empty keeps outputs deterministic after pops and reset.
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module demux1_2_ctrl1_buf #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] input0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] output0,
  output logic             valid0,
  input  logic             ready0,
  output logic [WIDTH-1:0] output1,
  output logic             valid1,
  input  logic             ready1
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]       stat0,
  output logic [7:0]       stat1
`endif
);
  localparam int NUM_Q = 2;

  logic [NUM_Q-1:0]            push, pop, valid, full, ready;
  logic [NUM_Q-1:0][WIDTH-1:0] rdata;

  // Only ctrl's select reaches in_ready; in_valid never does.
  assign in_ready = ~full[ctrl];
  assign ready    = {ready1, ready0};

  genvar q;
  generate
    for (q = 0; q < NUM_Q; q++) begin : g_q
      assign push[q] = in_valid & in_ready & (ctrl == q[0]);
      assign pop[q]  = valid[q] & ready[q];

      demux1_2_queue #(.WIDTH(WIDTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[q]),
        .wdata (input0),
        .pop   (pop[q]),
        .rdata (rdata[q]),
        .valid (valid[q]),
        .full  (full[q])
      );
    end
  endgenerate

  assign output0 = rdata[0];
  assign output1 = rdata[1];
  assign valid0  = valid[0];
  assign valid1  = valid[1];

`ifdef DEMUX_STATS_EN
  logic [NUM_Q-1:0][7:0] stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat <= '0;
    else begin
      for (int i = 0; i < NUM_Q; i++)
        if (pop[i]) stat[i] <= stat[i] + 8'd1; // wraps 255 -> 0
    end
  end

  assign stat0 = stat[0];
  assign stat1 = stat[1];
`endif
endmodule

// File: tb/tb_demux1_2_ctrl1_buf.sv
// Bench for demux1_2_ctrl1_buf: directed scenarios plus random traffic,
// checked against two SV queues modelling the FIFOs.
module tb_demux1_2_ctrl1_buf;
  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ctrl;
  logic [WIDTH-1:0] input0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] output0, output1;
  logic             valid0, valid1;
  logic             ready0, ready1;
`ifdef DEMUX_STATS_EN
  logic [7:0]       stat0, stat1;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [7:0]       st0 = 8'd0;
  logic [7:0]       st1 = 8'd0;

  always #5 clk = ~clk;

  demux1_2_ctrl1_buf #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (ctrl),
    .input0   (input0),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .output0  (output0),
    .valid0   (valid0),
    .ready0   (ready0),
    .output1  (output1),
    .valid1   (valid1),
    .ready1   (ready1)
`ifdef DEMUX_STATS_EN
    ,
    .stat0    (stat0),
    .stat1    (stat1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid0"}, 32'(valid0), 32'(q0.size() != 0));
    chk({tag, "_out0"}, 32'(output0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    chk({tag, "_valid1"}, 32'(valid1), 32'(q1.size() != 0));
    chk({tag, "_out1"}, 32'(output1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
`ifdef DEMUX_STATS_EN
    chk({tag, "_stat0"}, 32'(stat0), 32'(st0));
    chk({tag, "_stat1"}, 32'(stat1), 32'(st1));
`endif
  endtask

  // Called at a negedge: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input logic c, input logic [WIDTH-1:0] d,
                      input logic iv, input logic r0, input logic r1);
    logic rdy, acc, p0, p1;
    ctrl = c; input0 = d; in_valid = iv; ready0 = r0; ready1 = r1;
    #1;
    rdy = c ? (q1.size() != 2) : (q0.size() != 2);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    acc = iv && rdy;
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    if (p0) begin void'(q0.pop_front()); st0++; end
    if (p1) begin void'(q1.pop_front()); st1++; end
    if (acc) begin
      if (c) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); st0 = 8'd0; st1 = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; ctrl = 1'b0; input0 = '0; in_valid = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push to queue 0 appears one cycle later.
    step("s29", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("s29_out0_lit", 32'(output0), 32'h2);
    chk("s29_valid1_lit", 32'(valid1), 32'd0);

    // Fill queue 1; third word refused, queue 0 side still ready.
    step("s30a", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    step("s30b", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    step("s30c", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("s30_full_lit", 32'(in_ready), 32'd0);
    ctrl = 1'b0; #1;
    chk("s30_ctrl0_ready", 32'(in_ready), 32'd1);

    // Drain queue 1 in order.
    step("s31a", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("s31_out1_second", 32'(output1), 32'h3);
    step("s31b", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("s31_valid1_empty", 32'(valid1), 32'd0);

    // Push q0 while popping both queues.
    step("s32a", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("s32b", 1'b0, 2'b01, 1'b1, 1'b1, 1'b1);
    step("s32c", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Mid-cycle async reset with both queues loaded.
    step("s33a", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    step("s33b", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s33_in_ready", 32'(in_ready), 32'd1);
    check_outputs("s33_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("s26_first", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);

    // Stream 260 words through queue 0 so its pop counter wraps.
    for (int i = 0; i < 260; i++)
      step("s34", 1'b0, WIDTH'(i), 1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
